// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. It provides the registered position, region enables, syncs and start strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int X_W      = 11,
  parameter int Y_W      = 10
) (
  input  logic           pclk,
  input  logic           rstn,
  input  logic           ce,
  output logic           hen,
  output logic           ven,
  output logic           de,
  output logic           hs,
  output logic           vs,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]    frame_cnt
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_hen, r_ven, r_de, r_hs, r_vs, r_ls, r_fs;
  logic [X_W-1:0] w_x_nxt;
  logic [Y_W-1:0] w_y_nxt;
  logic           w_x_wrap, w_y_wrap, w_hs_act, w_vs_act;

  assign w_x_wrap = (r_x == H_LAST);
  assign w_y_wrap = (r_y == V_LAST);
  assign w_x_nxt  = w_x_wrap ? '0 : r_x + X_W'(1);
  assign w_y_nxt  = !w_x_wrap ? r_y : (w_y_wrap ? '0 : r_y + Y_W'(1));

  // Region flags are decoded from the next position so that they register together with x and y.
  assign w_hs_act = (w_x_nxt >= H_SYNC_BEG) && (w_x_nxt < H_SYNC_END);
  assign w_vs_act = (w_y_nxt >= V_SYNC_BEG) && (w_y_nxt < V_SYNC_END);

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_x   <= H_LAST;
      r_y   <= V_LAST;
      r_hen <= 1'b0;
      r_ven <= 1'b0;
      r_de  <= 1'b0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end else if (ce) begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_hen <= (w_x_nxt < H_ACT_END);
      r_ven <= (w_y_nxt < V_ACT_END);
      r_de  <= (w_x_nxt < H_ACT_END) && (w_y_nxt < V_ACT_END);
      r_hs  <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs  <= w_vs_act ? VS_POL : ~VS_POL;
      r_ls  <= w_x_wrap;
      r_fs  <= w_x_wrap && w_y_wrap;
    end else begin
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hen         = r_hen;
  assign ven         = r_ven;
  assign de          = r_de;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

`ifdef VGA_TIMING_FRAME_CNT_EN
  // The count updates on the same edge that raises frame_start.
  logic [15:0] r_frame_cnt;

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt <= '0;
    end else if (ce && w_x_wrap && w_y_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. It uses a default instance, a 1040x666 positive-sync instance and a small 15x8 instance.
// With VGA_TIMING_FRAME_CNT_EN defined, it also uses a 2x2 instance to exercise the frame counter wrap.
module tb_vga_timing_gen;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hen, ven, de, hs, vs, ls, fs;
  } exp_t;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic d_rstn = 1'b1, d_ce = 1'b0;
  logic a_rstn = 1'b1, a_ce = 1'b0;
  logic s_rstn = 1'b1, s_ce = 1'b0;
  logic d_hen, d_ven, d_de, d_hs, d_vs, d_ls, d_fs;
  logic a_hen, a_ven, a_de, a_hs, a_vs, a_ls, a_fs;
  logic s_hen, s_ven, s_de, s_hs, s_vs, s_ls, s_fs;
  logic [10:0] d_x, a_x;
  logic [9:0]  d_y, a_y;
  logic [3:0]  s_x;
  logic [2:0]  s_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fc, a_fc, s_fc, f_fc;
  logic f_rstn = 1'b1, f_ce = 1'b0;
  logic f_hen, f_ven, f_de, f_hs, f_vs, f_ls, f_fs;
  logic [0:0] f_x, f_y;
`endif

  vga_timing_gen u_def (
    .pclk(pclk), .rstn(d_rstn), .ce(d_ce), .hen(d_hen), .ven(d_ven), .de(d_de),
    .hs(d_hs), .vs(d_vs), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(56), .H_SYNC(120), .H_BP(64),
    .V_ACTIVE(600), .V_FP(37), .V_SYNC(6), .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .X_W(11), .Y_W(10)
  ) u_alt (
    .pclk(pclk), .rstn(a_rstn), .ce(a_ce), .hen(a_hen), .ven(a_ven), .de(a_de),
    .hs(a_hs), .vs(a_vs), .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .X_W(4), .Y_W(3)
  ) u_sml (
    .pclk(pclk), .rstn(s_rstn), .ce(s_ce), .hen(s_hen), .ven(s_ven), .de(s_de),
    .hs(s_hs), .vs(s_vs), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(1),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .X_W(1), .Y_W(1)
  ) u_fc (
    .pclk(pclk), .rstn(f_rstn), .ce(f_ce), .hen(f_hen), .ven(f_ven), .de(f_de),
    .hs(f_hs), .vs(f_vs), .x(f_x), .y(f_y), .line_start(f_ls), .frame_start(f_fs),
    .frame_cnt(f_fc)
  );
`endif

  int HA [3]  = '{640, 800, 8};
  int HF [3]  = '{16, 56, 2};
  int HSW [3] = '{96, 120, 3};
  int HB [3]  = '{48, 64, 2};
  int VA [3]  = '{480, 600, 4};
  int VF [3]  = '{10, 37, 1};
  int VSW [3] = '{2, 6, 2};
  int VB [3]  = '{33, 23, 1};
  bit HP [3]  = '{1'b0, 1'b1, 1'b0};
  bit VP [3]  = '{1'b0, 1'b1, 1'b0};

  int   mx [3];
  int   my [3];
  exp_t q_exp [$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic int htot(int w);
    return HA[w] + HF[w] + HSW[w] + HB[w];
  endfunction

  function automatic int vtot(int w);
    return VA[w] + VF[w] + VSW[w] + VB[w];
  endfunction

  function automatic exp_t model_out(int w, int px, int py, bit ls, bit fs);
    exp_t e;
    int   hs0, vs0;
    hs0   = HA[w] + HF[w];
    vs0   = VA[w] + VF[w];
    e.x   = 16'(px);
    e.y   = 16'(py);
    e.hen = (px < HA[w]);
    e.ven = (py < VA[w]);
    e.de  = e.hen & e.ven;
    e.hs  = (px >= hs0 && px < hs0 + HSW[w]) ? HP[w] : ~HP[w];
    e.vs  = (py >= vs0 && py < vs0 + VSW[w]) ? VP[w] : ~VP[w];
    e.ls  = ls;
    e.fs  = fs;
    return e;
  endfunction

  function automatic exp_t rst_exp(int w);
    exp_t e;
    e     = '0;
    e.x   = 16'(htot(w) - 1);
    e.y   = 16'(vtot(w) - 1);
    e.hs  = ~HP[w];
    e.vs  = ~VP[w];
    return e;
  endfunction

  function automatic exp_t get_act(int w);
    exp_t a;
    a = '0;
    case (w)
      0: begin
        a.x = 16'(d_x); a.y = 16'(d_y); a.hen = d_hen; a.ven = d_ven; a.de = d_de;
        a.hs = d_hs; a.vs = d_vs; a.ls = d_ls; a.fs = d_fs;
      end
      1: begin
        a.x = 16'(a_x); a.y = 16'(a_y); a.hen = a_hen; a.ven = a_ven; a.de = a_de;
        a.hs = a_hs; a.vs = a_vs; a.ls = a_ls; a.fs = a_fs;
      end
      default: begin
        a.x = 16'(s_x); a.y = 16'(s_y); a.hen = s_hen; a.ven = s_ven; a.de = s_de;
        a.hs = s_hs; a.vs = s_vs; a.ls = s_ls; a.fs = s_fs;
      end
    endcase
    return a;
  endfunction

  task automatic set_ce(int w, bit v);
    case (w)
      0: d_ce = v;
      1: a_ce = v;
      default: s_ce = v;
    endcase
  endtask

  task automatic set_rstn(int w, bit v);
    case (w)
      0: d_rstn = v;
      1: a_rstn = v;
      default: s_rstn = v;
    endcase
  endtask

  // Advances the reference position, queues the expected outputs and returns 1 ns after the next edge.
  task automatic tick(int w, bit ce_v);
    bit ls, fs;
    ls = 1'b0;
    fs = 1'b0;
    set_ce(w, ce_v);
    if (ce_v) begin
      if (mx[w] == htot(w) - 1) begin
        mx[w] = 0;
        my[w] = (my[w] == vtot(w) - 1) ? 0 : my[w] + 1;
        ls    = 1'b1;
        fs    = (my[w] == 0);
      end else begin
        mx[w] = mx[w] + 1;
      end
    end
    q_exp.push_back(model_out(w, mx[w], my[w], ls, fs));
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, a;
    #2;
    d_rstn = 1'b0; a_rstn = 1'b0; s_rstn = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      e = rst_exp(w);
      a = get_act(w);
      mx[w] = htot(w) - 1;
      my[w] = vtot(w) - 1;
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL reset_val[%0d]: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
                 w, a.x, a.y, {a.hen, a.ven, a.de, a.hs, a.vs, a.ls, a.fs},
                 e.x, e.y, {e.hen, e.ven, e.de, e.hs, e.vs, e.ls, e.fs});
      end
    end
    d_ce = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    d_ce = 1'b0;
    e = rst_exp(0);
    a = get_act(0);
    n_cmp++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL reset_hold_ce: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
               a.x, a.y, {a.hen, a.ven, a.de, a.hs, a.vs, a.ls, a.fs},
               e.x, e.y, {e.hen, e.ven, e.de, e.hs, e.vs, e.ls, e.fs});
    end
  endtask

  task automatic test_default_lines();
    exp_t e, a;
    int   last_ls, hs_low, hen_low;
    d_rstn = 1'b1;
    tick(0, 1'b1);
    e = q_exp.pop_front();
    a = get_act(0);
    n_cmp++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL first_edge: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
               a.x, a.y, {a.hen, a.ven, a.de, a.hs, a.vs, a.ls, a.fs},
               e.x, e.y, {e.hen, e.ven, e.de, e.hs, e.vs, e.ls, e.fs});
    end
    n_cmp++;
    if ({a.de, a.ls, a.fs} !== 3'b111) begin
      n_mis++;
      $display("FAIL first_edge_strobes: got de/ls/fs=%b, want 111", {a.de, a.ls, a.fs});
    end
    last_ls = 0;
    hs_low  = 0;
    hen_low = 0;
    for (int i = 1; i <= 3 * 800; i++) begin
      tick(0, 1'b1);
      e = q_exp.pop_front();
      a = get_act(0);
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL default_line i=%0d: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
                 i, a.x, a.y, {a.hen, a.ven, a.de, a.hs, a.vs, a.ls, a.fs},
                 e.x, e.y, {e.hen, e.ven, e.de, e.hs, e.vs, e.ls, e.fs});
      end
      if (i <= 800 && a.hs === 1'b0) hs_low++;
      if (i <= 800 && a.hen === 1'b0) hen_low++;
      if (a.ls === 1'b1) begin
        n_cmp++;
        if (i - last_ls != 800) begin
          n_mis++;
          $display("FAIL line_period: got %0d, want 800", i - last_ls);
        end
        last_ls = i;
      end
    end
    n_cmp++;
    if (hs_low != 96) begin
      n_mis++;
      $display("FAIL hs_low_count: got %0d, want 96", hs_low);
    end
    n_cmp++;
    if (hen_low != 160) begin
      n_mis++;
      $display("FAIL hen_low_count: got %0d, want 160", hen_low);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 1'b0);
      e = q_exp.pop_front();
      a = get_act(0);
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL ce_hold i=%0d: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
                 i, a.x, a.y, {a.hen, a.ven, a.de, a.hs, a.vs, a.ls, a.fs},
                 e.x, e.y, {e.hen, e.ven, e.de, e.hs, e.vs, e.ls, e.fs});
      end
    end
  endtask

  task automatic test_small_frames();
    exp_t e, a;
    int   last_fs, vs_low;
    logic prev_vs;
    s_rstn  = 1'b1;
    last_fs = 0;
    vs_low  = 0;
    prev_vs = 1'b1;
    for (int i = 0; i <= 240; i++) begin
      tick(2, 1'b1);
      e = q_exp.pop_front();
      a = get_act(2);
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL small_frame i=%0d: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
                 i, a.x, a.y, {a.hen, a.ven, a.de, a.hs, a.vs, a.ls, a.fs},
                 e.x, e.y, {e.hen, e.ven, e.de, e.hs, e.vs, e.ls, e.fs});
      end
      if (i >= 1 && i <= 120 && a.vs === 1'b0) vs_low++;
      if (a.vs !== prev_vs) begin
        n_cmp++;
        if (a.x !== 16'd0) begin
          n_mis++;
          $display("FAIL vs_edge_x: got x=%0d, want 0", a.x);
        end
      end
      prev_vs = a.vs;
      if (i > 0 && a.fs === 1'b1) begin
        n_cmp++;
        if (i - last_fs != 120) begin
          n_mis++;
          $display("FAIL frame_period: got %0d, want 120", i - last_fs);
        end
        last_fs = i;
      end
    end
    n_cmp++;
    if (vs_low != 30) begin
      n_mis++;
      $display("FAIL vs_low_count: got %0d, want 30", vs_low);
    end
  endtask

  task automatic test_ce_odd();
    exp_t e, a;
    int   n_fs, first_fs;
    logic prev_fs;
    n_fs     = 0;
    first_fs = -1;
    prev_fs  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick(2, bit'(i % 2));
      e = q_exp.pop_front();
      a = get_act(2);
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL ce_odd i=%0d: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
                 i, a.x, a.y, {a.hen, a.ven, a.de, a.hs, a.vs, a.ls, a.fs},
                 e.x, e.y, {e.hen, e.ven, e.de, e.hs, e.vs, e.ls, e.fs});
      end
      if (a.fs === 1'b1) begin
        n_cmp++;
        if (prev_fs === 1'b1) begin
          n_mis++;
          $display("FAIL ce_odd_fs_width: got 2+ cycles high, want 1");
        end
        if (first_fs >= 0) begin
          n_cmp++;
          if (i - first_fs != 240) begin
            n_mis++;
            $display("FAIL ce_odd_period: got %0d, want 240", i - first_fs);
          end
        end
        first_fs = i;
        n_fs++;
      end
      prev_fs = a.fs;
    end
    s_ce = 1'b0;
    n_cmp++;
    if (n_fs != 2) begin
      n_mis++;
      $display("FAIL ce_odd_fs_count: got %0d, want 2", n_fs);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e, a;
    bit   hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick(2, 1'b1);
      e = q_exp.pop_front();
      a = get_act(2);
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL mid_run i=%0d: got x=%0d y=%0d, want x=%0d y=%0d", i, a.x, a.y, e.x, e.y);
      end
      hit = (mx[2] == 5 && my[2] == 3);
    end
    n_cmp++;
    if (!hit) begin
      n_mis++;
      $display("FAIL mid_reset_reach: got no visit to (5,3) in 200 cycles, want one");
    end
    #3;
    s_rstn = 1'b0;
    #1;
    e = rst_exp(2);
    a = get_act(2);
    mx[2] = htot(2) - 1;
    my[2] = vtot(2) - 1;
    n_cmp++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL mid_reset_async: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
               a.x, a.y, {a.hen, a.ven, a.de, a.hs, a.vs, a.ls, a.fs},
               e.x, e.y, {e.hen, e.ven, e.de, e.hs, e.vs, e.ls, e.fs});
    end
    @(posedge pclk);
    #1;
    a = get_act(2);
    n_cmp++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL mid_reset_hold: got x=%0d y=%0d, want x=%0d y=%0d", a.x, a.y, e.x, e.y);
    end
    s_rstn = 1'b1;
    tick(2, 1'b1);
    e = q_exp.pop_front();
    a = get_act(2);
    s_ce = 1'b0;
    n_cmp++;
    if (a !== e || a.fs !== 1'b1) begin
      n_mis++;
      $display("FAIL mid_reset_release: got x=%0d y=%0d fs=%b, want x=%0d y=%0d fs=1",
               a.x, a.y, a.fs, e.x, e.y);
    end
  endtask

  task automatic test_alt_params();
    exp_t e, a;
    int   last_ls, hs_high;
    a_rstn  = 1'b1;
    last_ls = 0;
    hs_high = 0;
    for (int i = 0; i <= 2 * 1040; i++) begin
      tick(1, 1'b1);
      e = q_exp.pop_front();
      a = get_act(1);
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL alt_line i=%0d: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
                 i, a.x, a.y, {a.hen, a.ven, a.de, a.hs, a.vs, a.ls, a.fs},
                 e.x, e.y, {e.hen, e.ven, e.de, e.hs, e.vs, e.ls, e.fs});
      end
      if (i >= 1 && i <= 1040 && a.hs === 1'b1) hs_high++;
      if (a.x == 16'd856 || a.x == 16'd975) begin
        n_cmp++;
        if (a.hs !== 1'b1) begin
          n_mis++;
          $display("FAIL alt_hs_edge_in x=%0d: got %b, want 1", a.x, a.hs);
        end
      end
      if (a.x == 16'd855 || a.x == 16'd976) begin
        n_cmp++;
        if (a.hs !== 1'b0) begin
          n_mis++;
          $display("FAIL alt_hs_edge_out x=%0d: got %b, want 0", a.x, a.hs);
        end
      end
      if (i > 0 && a.ls === 1'b1) begin
        n_cmp++;
        if (i - last_ls != 1040) begin
          n_mis++;
          $display("FAIL alt_line_period: got %0d, want 1040", i - last_ls);
        end
        last_ls = i;
      end
    end
    a_ce = 1'b0;
    n_cmp++;
    if (hs_high != 120) begin
      n_mis++;
      $display("FAIL alt_hs_high_count: got %0d, want 120", hs_high);
    end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int n_fs;
    f_rstn = 1'b0;
    #1;
    n_cmp++;
    if (f_fc !== 16'd0) begin
      n_mis++;
      $display("FAIL frame_cnt_reset: got %0d, want 0", f_fc);
    end
    @(posedge pclk);
    #1;
    f_rstn = 1'b1;
    f_ce   = 1'b1;
    n_fs   = 0;
    for (int i = 0; i < 65536 * 4 + 8 && n_fs < 65536; i++) begin
      @(posedge pclk);
      #1;
      if (f_fs === 1'b1) begin
        n_fs++;
        if (n_fs == 1 || n_fs == 65535 || n_fs == 65536) begin
          n_cmp++;
          if (f_fc !== 16'(n_fs)) begin
            n_mis++;
            $display("FAIL frame_cnt at frame %0d: got %0d, want %0d", n_fs, f_fc, 16'(n_fs));
          end
        end
      end
    end
    f_ce = 1'b0;
    n_cmp++;
    if (n_fs != 65536) begin
      n_mis++;
      $display("FAIL frame_cnt_frames: got %0d, want 65536", n_fs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_lines();
    test_small_frames();
    test_ce_odd();
    test_mid_reset();
    test_alt_params();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
